// File: rtl/data_stack_if.sv
// Decoder/ALU-facing bundle of the data stack: op stream in, operand registers and status out.
interface data_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]       op;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             err_over;
  logic             err_under;

  modport master (
    output op, din, alu_out,
    input  tos, nos, count, empty, full, err_over, err_under
  );

  modport slave (
    input  op, din, alu_out,
    output tos, nos, count, empty, full, err_over, err_under
  );
endinterface

// File: rtl/data_stack.sv
// Register-based data stack: TOS/NOS in flops for zero-latency ALU operands,
// deeper entries in a register array that spills/fills one word per op.
module data_stack #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  data_stack_if.slave bus
);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int MEM_N = DEPTH - 2;
  localparam int AW    = (MEM_N > 1) ? $clog2(MEM_N) : 1;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_PUSH   = 3'd1,
    OP_POP    = 3'd2,
    OP_BINOP  = 3'd3,
    OP_DUP    = 3'd4,
    OP_SWAP   = 3'd5,
    OP_OVER   = 3'd6,
    OP_SETTOP = 3'd7
  } op_e;

  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             err_over_q, err_over_d;
  logic             err_under_q, err_under_d;

  logic [WIDTH-1:0] mem_q [MEM_N];

  logic             needs_one, needs_two, grows;
  logic             underflow, overflow;
  logic             spill_en;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [WIDTH-1:0] fill_val;

  // Entry count-2 is the slot just below NOS; the slot below that refills NOS.
  assign wr_idx   = AW'(count_q - CW'(2));
  assign rd_idx   = AW'(count_q - CW'(3));
  assign fill_val = (count_q >= CW'(3)) ? mem_q[rd_idx] : '0;

  always_comb begin
    tos_d       = tos_q;
    nos_d       = nos_q;
    count_d     = count_q;
    err_over_d  = err_over_q;
    err_under_d = err_under_q;
    spill_en    = 1'b0;
    needs_one   = 1'b0;
    needs_two   = 1'b0;
    grows       = 1'b0;

    case (op_e'(bus.op))
      OP_PUSH:   grows = 1'b1;
      OP_POP:    needs_one = 1'b1;
      OP_BINOP:  needs_two = 1'b1;
      OP_DUP:    begin needs_one = 1'b1; grows = 1'b1; end
      OP_SWAP:   needs_two = 1'b1;
      OP_OVER:   begin needs_two = 1'b1; grows = 1'b1; end
      OP_SETTOP: needs_one = 1'b1;
      default:   ;
    endcase

    underflow = (needs_one && (count_q == '0)) || (needs_two && (count_q < CW'(2)));
    overflow  = grows && (count_q == CW'(DEPTH));

    if (underflow) begin
      err_under_d = 1'b1;
    end else if (overflow) begin
      err_over_d = 1'b1;
    end else begin
      spill_en = grows && (count_q >= CW'(2));
      case (op_e'(bus.op))
        OP_PUSH: begin
          tos_d   = bus.din;
          nos_d   = tos_q;
          count_d = count_q + CW'(1);
        end
        OP_POP: begin
          tos_d   = nos_q;
          nos_d   = fill_val;
          count_d = count_q - CW'(1);
        end
        OP_BINOP: begin
          tos_d   = bus.alu_out;
          nos_d   = fill_val;
          count_d = count_q - CW'(1);
        end
        OP_DUP: begin
          nos_d   = tos_q;
          count_d = count_q + CW'(1);
        end
        OP_SWAP: begin
          tos_d = nos_q;
          nos_d = tos_q;
        end
        OP_OVER: begin
          tos_d   = nos_q;
          nos_d   = tos_q;
          count_d = count_q + CW'(1);
        end
        OP_SETTOP: tos_d = bus.din;
        default:   ;
      endcase
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tos_q       <= '0;
      nos_q       <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      err_over_q  <= 1'b0;
      err_under_q <= 1'b0;
    end else begin
      tos_q       <= tos_d;
      nos_q       <= nos_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      err_over_q  <= err_over_d;
      err_under_q <= err_under_d;
    end
  end

  // Array contents are don't-care after reset, so no reset on the spill write.
  always_ff @(posedge clk) begin
    if (!reset && spill_en) begin
      mem_q[wr_idx] <= nos_q;
    end
  end

  assign bus.tos       = tos_q;
  assign bus.nos       = nos_q;
  assign bus.count     = count_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.err_over  = err_over_q;
  assign bus.err_under = err_under_q;
endmodule

// File: doc/data_stack.md
# data_stack

- Register-based data stack that feeds the CPU's combinational ALU.
- Holds top-of-stack (TOS) and next-of-stack (NOS) in registers, so both ALU operands are available at the start of every cycle. Deeper entries live in a register array.
- Accepts one stack operation per cycle from the decoder, including the ALU write-back (pop two, push result).
- Sits between instruction decode/load-store and the ALU; ALU operand `a` = NOS, operand `b` = TOS.

## Interface

**Parameters**
- DEPTH, 32: total stack capacity in entries (≥ 3); array holds DEPTH-2 entries.
- WIDTH, 16: data word width.

**Ports**
- clk, input, 1: single clock; all state changes on rising edge.
- reset, input, 1: synchronous, active-high.
- op, input, 3: 0 NOP, 1 PUSH, 2 POP, 3 BINOP, 4 DUP, 5 SWAP, 6 OVER, 7 SETTOP.
- din, input, WIDTH: value for PUSH and SETTOP.
- alu_out, input, WIDTH: ALU result, consumed by BINOP.
- tos, output, WIDTH: top entry; 0 when count==0. Drives ALU `b`.
- nos, output, WIDTH: second entry; 0 when count<2. Drives ALU `a`.
- count, output, $clog2(DEPTH+1): number of valid entries.
- empty, output, 1: count==0.
- full, output, 1: count==DEPTH.
- err_over, output, 1: sticky overflow flag.
- err_under, output, 1: sticky underflow flag.

## Operation

- **Reset:** count=0, tos=0, nos=0, err_over=0, err_under=0, empty=1, full=0. Array contents are don't-care.
- **Operations** (state shown before the clock edge → after):
  - PUSH: nos←tos, tos←din, count+1; the old nos spills to array[count-2] when count≥2.
  - POP: tos←nos, nos←array[count-3] (or 0 if count<3), count-1.
  - BINOP: tos←alu_out, nos←array[count-3] (or 0 if count<3), count-1.
  - DUP: nos←tos, tos unchanged, old nos spills, count+1.
  - SWAP: exchange tos and nos; count unchanged.
  - OVER: tos←nos, nos←tos, old nos spills, count+1.
  - SETTOP: tos←din; count unchanged.
  - NOP: no change.
- **Required entries:**
  - POP, DUP, SETTOP need ≥1.
  - BINOP, SWAP, OVER need ≥2.
  - PUSH, DUP, OVER need count<DEPTH.
- **Error handling:**
  - Underflow: set err_under, leave all other state unchanged.
  - Overflow: set err_over, leave all other state unchanged.
  - Sticky flags clear only on reset.
  - An illegal op is never partially applied.
- **Hidden slots:** when an entry is removed, any register or array slot it leaves unused reads as 0 on tos/nos. Array slots may keep stale data.
- **Widths:** all moves are WIDTH bits exact; no arithmetic beyond count ±1.

## Timing

- One op per cycle, no stall, no handshake. op is sampled every rising edge.
- tos, nos, count, empty, full and the error flags are registered; they reflect an op in the cycle after its edge.
- BINOP: the ALU computes combinationally from the current tos/nos; alu_out is sampled at the same edge as op. Result is visible on tos one cycle later.
- Back-to-back BINOPs are legal; each uses the previous one's result.
- Array spill/fill completes within the op's cycle; the next op sees a consistent stack.
- Reset has priority over op in the same cycle.
- Reset mid-sequence discards all entries; the first op after reset sees an empty stack.
- Boundary behaviour:
  - PUSH at count==DEPTH-1 succeeds and sets full.
  - The next PUSH errors, with count staying at DEPTH.
  - POP at count==1 leaves tos=0, empty=1.

## Test plan

- **Reset:** assert reset 2 cycles with op=PUSH, din=0x1234 → count=0, tos=0, nos=0, flags 0.
- **Binop:** PUSH 0x0005, PUSH 0x0003, BINOP with alu_out=0x0008 → tos=0x0008, nos=0, count=1.
- **Spill/fill:** PUSH 1,2,3,4, then POP ×3 → tos sequence 3,2,1; nos sequence 2,1,0; count ends 1.
- **Overflow:** PUSH DEPTH times (values 1..32) → full=1, tos=32. One more PUSH 99 → err_over=1, tos=32, count=32. Then POP → tos=31, err_over stays 1.
- **Underflow:** from empty, SWAP → err_under=1, count=0. Then PUSH 7, DUP, OVER → tos=7, nos=7, count=3.
- **SWAP/SETTOP/reset:** PUSH 0xAAAA, PUSH 0x5555, SWAP → tos=0xAAAA, nos=0x5555. SETTOP 0xFFFF → tos=0xFFFF. Reset on the next cycle → all outputs 0, empty=1.
